// File: rtl/router_rr_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : router_rr_scheduler_if
// Brief    : Shared-bus signal bundle between the terminal interfaces and the
//            router's round-robin scheduler.
// Revision : 1.0
// ============================================================================
interface router_rr_scheduler_if #(
    parameter int PCKG_SZ = 40,
    parameter int CNT_W   = 8
);
    logic [3:0]           pndng_i;
    logic [4*PCKG_SZ-1:0] data_out_i;
    logic [7:0]           tgt_i;
    logic [3:0]           full_i;
    logic [1:0]           trn;
    logic                 push_i;
    logic                 pop_i;
    logic [PCKG_SZ-1:0]   data_in_i;
    logic                 busy;
    logic [CNT_W-1:0]     skip_cnt;

    modport master (
        input  pndng_i, data_out_i, tgt_i, full_i,
        output trn, push_i, pop_i, data_in_i, busy, skip_cnt
    );

    modport slave (
        output pndng_i, data_out_i, tgt_i, full_i,
        input  trn, push_i, pop_i, data_in_i, busy, skip_cnt
    );
endinterface
`default_nettype wire

// File: rtl/router_rr_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : router_rr_scheduler
// Brief    : Round-robin grant of four terminal interfaces onto the router's
//            internal bus, with a bounded wait on full destinations.
// Revision : 1.0
// ============================================================================
module router_rr_scheduler #(
    parameter int PCKG_SZ  = 40,
    parameter int WAIT_MAX = 16,
    parameter int CNT_W    = 8
) (
    input  wire logic              clk,
    input  wire logic              rst,
    router_rr_scheduler_if.master  bus
);
    localparam int WAIT_W = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
    localparam logic [WAIT_W-1:0] c_WAIT_LAST = WAIT_W'(WAIT_MAX - 1);
    localparam logic [CNT_W-1:0]  c_SKIP_SAT  = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_PUSH  = 2'd2,
        ST_POP   = 2'd3
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [1:0]         r_ptr, w_ptr_nxt;
    logic [1:0]         r_trn, w_trn_nxt;
    logic [1:0]         r_tgt_l, w_tgt_l_nxt;
    logic [PCKG_SZ-1:0] r_data, w_data_nxt;
    logic [WAIT_W-1:0]  r_wait, w_wait_nxt;
    logic [CNT_W-1:0]   r_skip, w_skip_nxt;

    logic [PCKG_SZ-1:0] w_pkt [4];
    logic [1:0]         w_tgt [4];
    logic [1:0]         w_sel;

    for (genvar k = 0; k < 4; k++) begin : g_slice
        assign w_pkt[k] = bus.data_out_i[k*PCKG_SZ +: PCKG_SZ];
        assign w_tgt[k] = bus.tgt_i[2*k +: 2];
    end

    // Scan from the farthest candidate down so the nearest pending one after ptr wins.
    always_comb begin
        w_sel = 2'd0;
        for (int i = 4; i >= 1; i--) begin
            if (bus.pndng_i[r_ptr + 2'(i)]) begin
                w_sel = r_ptr + 2'(i);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_ptr   <= 2'd3;
            r_trn   <= 2'd0;
            r_tgt_l <= 2'd0;
            r_data  <= '0;
            r_wait  <= '0;
            r_skip  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_trn   <= w_trn_nxt;
            r_tgt_l <= w_tgt_l_nxt;
            r_data  <= w_data_nxt;
            r_wait  <= w_wait_nxt;
            r_skip  <= w_skip_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_trn_nxt   = r_trn;
        w_tgt_l_nxt = r_tgt_l;
        w_data_nxt  = r_data;
        w_wait_nxt  = r_wait;
        w_skip_nxt  = r_skip;
        case (r_state)
            ST_IDLE: begin
                if (bus.pndng_i != 4'd0) begin
                    w_trn_nxt   = w_sel;
                    w_data_nxt  = w_pkt[w_sel];
                    w_tgt_l_nxt = w_tgt[w_sel];
                    w_wait_nxt  = '0;
                    w_state_nxt = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (!bus.pndng_i[r_trn]) begin
                    w_ptr_nxt   = r_trn;
                    w_state_nxt = ST_IDLE;
                end else if (!bus.full_i[r_tgt_l]) begin
                    w_state_nxt = ST_PUSH;
                end else if (r_wait == c_WAIT_LAST) begin
                    // Give up on this grant; the stalled requester drops to lowest priority.
                    w_ptr_nxt   = r_trn;
                    w_state_nxt = ST_IDLE;
                    if (r_skip != c_SKIP_SAT) begin
                        w_skip_nxt = r_skip + CNT_W'(1);
                    end
                end else begin
                    w_wait_nxt = r_wait + WAIT_W'(1);
                end
            end
            ST_PUSH: begin
                w_state_nxt = ST_POP;
            end
            ST_POP: begin
                w_ptr_nxt   = r_trn;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign bus.trn       = r_trn;
    assign bus.data_in_i = r_data;
    assign bus.push_i    = (r_state == ST_PUSH);
    assign bus.pop_i     = (r_state == ST_POP);
    assign bus.busy      = (r_state != ST_IDLE);
    assign bus.skip_cnt  = r_skip;

endmodule
`default_nettype wire

// File: tb/tb_router_rr_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_router_rr_scheduler
// Brief    : Directed and randomized bench for router_rr_scheduler against a
//            cycle-level behavioural model of the grant rules.
// Revision : 1.0
// ============================================================================
module tb_router_rr_scheduler;
    localparam int PCKG_SZ  = 40;
    localparam int WAIT_MAX = 4;
    localparam int CNT_W    = 3;
    localparam int SKIP_MAX = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    router_rr_scheduler_if #(.PCKG_SZ(PCKG_SZ), .CNT_W(CNT_W)) bus ();

    router_rr_scheduler #(
        .PCKG_SZ (PCKG_SZ),
        .WAIT_MAX(WAIT_MAX),
        .CNT_W   (CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.master)
    );

    int total = 0;
    int bad   = 0;

    logic [PCKG_SZ-1:0] pkt [4];
    logic [1:0]         tg  [4];

    // Model: stage 0 idle, 1 waiting on destination, 2 push, 3 pop.
    int                 m_stage, m_ptr, m_trn, m_tgt, m_waited, m_skip;
    logic [PCKG_SZ-1:0] m_data;

    function automatic void model_reset();
        m_stage  = 0;
        m_ptr    = 3;
        m_trn    = 0;
        m_tgt    = 0;
        m_waited = 0;
        m_skip   = 0;
        m_data   = '0;
    endfunction

    task automatic apply();
        for (int k = 0; k < 4; k++) begin
            bus.data_out_i[k*PCKG_SZ +: PCKG_SZ] = pkt[k];
            bus.tgt_i[2*k +: 2]                  = tg[k];
        end
    endtask

    task automatic model_edge();
        int k;
        case (m_stage)
            0: if (bus.pndng_i != 4'd0) begin
                for (int j = 4; j >= 1; j--) begin
                    k = (m_ptr + j) % 4;
                    if (bus.pndng_i[k]) m_trn = k;
                end
                m_data   = pkt[m_trn];
                m_tgt    = tg[m_trn];
                m_waited = 0;
                m_stage  = 1;
            end
            1: if (!bus.pndng_i[m_trn]) begin
                m_ptr   = m_trn;
                m_stage = 0;
            end else if (!bus.full_i[m_tgt]) begin
                m_stage = 2;
            end else if (m_waited + 1 >= WAIT_MAX) begin
                m_ptr   = m_trn;
                m_stage = 0;
                m_skip  = (m_skip < SKIP_MAX) ? m_skip + 1 : SKIP_MAX;
            end else begin
                m_waited = m_waited + 1;
            end
            2: m_stage = 3;
            default: begin
                m_ptr   = m_trn;
                m_stage = 0;
            end
        endcase
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        chk("trn",       64'(bus.trn),       64'(m_trn));
        chk("push_i",    64'(bus.push_i),    64'(m_stage == 2));
        chk("pop_i",     64'(bus.pop_i),     64'(m_stage == 3));
        chk("data_in_i", 64'(bus.data_in_i), 64'(m_data));
        chk("busy",      64'(bus.busy),      64'(m_stage != 0));
        chk("skip_cnt",  64'(bus.skip_cnt),  64'(m_skip));
    endtask

    task automatic step();
        @(posedge clk);
        if (!rst) model_edge();
        #1;
        check_model();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    int n_push;
    int push_trn [8];
    int push_cyc [8];

    initial begin
        bus.pndng_i = 4'd0;
        bus.full_i  = 4'd0;
        for (int k = 0; k < 4; k++) begin
            pkt[k] = PCKG_SZ'({$urandom, $urandom});
            tg[k]  = 2'(k);
        end
        apply();
        do_reset();
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_trn",  64'(bus.trn),  64'd0);
        chk("rst_skip", 64'(bus.skip_cnt), 64'd0);
        chk("rst_data", 64'(bus.data_in_i), 64'd0);

        // Single uncontended request from interface 2.
        pkt[2] = 40'hA5_1234_5678;
        tg[2]  = 2'd1;
        apply();
        bus.pndng_i = 4'b0100;
        step();
        chk("t1_trn",  64'(bus.trn), 64'd2);
        chk("t1_data", 64'(bus.data_in_i), 64'hA5_1234_5678);
        step();
        chk("t1_push", 64'(bus.push_i), 64'd1);
        step();
        chk("t1_pop",  64'(bus.pop_i), 64'd1);
        bus.pndng_i = 4'b0000;
        step();
        chk("t1_idle", 64'(bus.busy), 64'd0);

        // All four pending: rotation 0,1,2,3,0 with pushes 4 cycles apart.
        do_reset();
        bus.pndng_i = 4'b1111;
        n_push = 0;
        for (int c = 0; c < 20; c++) begin
            step();
            if (bus.push_i && n_push < 8) begin
                push_trn[n_push] = int'(bus.trn);
                push_cyc[n_push] = c;
                n_push++;
            end
        end
        chk("t2_npush", 64'(n_push >= 5), 64'd1);
        for (int i = 0; i < 5; i++) begin
            chk("t2_order", 64'(push_trn[i]), 64'(i % 4));
            if (i > 0) chk("t2_gap", 64'(push_cyc[i] - push_cyc[i-1]), 64'd4);
        end
        bus.pndng_i = 4'b0000;

        // Destination stays full: two timeouts on interface 1.
        do_reset();
        tg[1] = 2'd3;
        apply();
        bus.full_i  = 4'b1000;
        bus.pndng_i = 4'b0010;
        n_push = 0;
        for (int c = 0; c < 5; c++) begin
            step();
            if (bus.push_i || bus.pop_i) n_push++;
        end
        chk("t3_busy1", 64'(bus.busy), 64'd0);
        chk("t3_skip1", 64'(bus.skip_cnt), 64'd1);
        chk("t3_nopush", 64'(n_push), 64'd0);
        step();
        chk("t3_regrant", 64'(bus.trn), 64'd1);
        for (int c = 0; c < 4; c++) step();
        chk("t3_skip2", 64'(bus.skip_cnt), 64'd2);
        bus.pndng_i = 4'b0000;

        // Destination frees up after two waiting cycles.
        do_reset();
        bus.full_i  = 4'b1000;
        bus.pndng_i = 4'b0010;
        step();
        step();
        bus.full_i = 4'b0000;
        step();
        chk("t4_push", 64'(bus.push_i), 64'd1);
        step();
        chk("t4_pop",  64'(bus.pop_i), 64'd1);
        chk("t4_skip", 64'(bus.skip_cnt), 64'd0);
        bus.pndng_i = 4'b0000;

        // Asynchronous reset landing in the push cycle.
        do_reset();
        bus.pndng_i = 4'b0010;
        step();
        step();
        chk("t5_push", 64'(bus.push_i), 64'd1);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        chk("t5_push0", 64'(bus.push_i), 64'd0);
        chk("t5_pop0",  64'(bus.pop_i),  64'd0);
        chk("t5_trn0",  64'(bus.trn),    64'd0);
        chk("t5_busy0", 64'(bus.busy),   64'd0);
        bus.pndng_i = 4'b1111;
        @(negedge clk);
        rst = 1'b0;
        step();
        chk("t5_prio0", 64'(bus.trn), 64'd0);
        bus.pndng_i = 4'b0000;

        // Withdrawn request in the wait state passes priority onward.
        do_reset();
        tg[0] = 2'd2;
        apply();
        bus.full_i  = 4'b0100;
        bus.pndng_i = 4'b0011;
        step();
        chk("t6_trn0", 64'(bus.trn), 64'd0);
        bus.pndng_i = 4'b0010;
        step();
        chk("t6_idle", 64'(bus.busy), 64'd0);
        chk("t6_nopush", 64'(bus.push_i | bus.pop_i), 64'd0);
        step();
        chk("t6_trn1", 64'(bus.trn), 64'd1);

        // Randomized traffic with occasional asynchronous resets.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(3) == 0) bus.pndng_i = 4'($urandom);
            bus.full_i = 4'd0;
            for (int k = 0; k < 4; k++) begin
                if ($urandom_range(9) < 4) bus.full_i[k] = 1'b1;
                if ($urandom_range(3) == 0) tg[k] = 2'($urandom);
                pkt[k] = PCKG_SZ'({$urandom, $urandom});
            end
            apply();
            step();
            if ($urandom_range(299) == 0) begin
                #2;
                rst = 1'b1;
                model_reset();
                #1;
                check_model();
                @(negedge clk);
                rst = 1'b0;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/router_rr_scheduler.md
Name: router_rr_scheduler

Overview:
- Round-robin scheduler for the shared internal bus of one mesh router.
- Four terminal interfaces raise pending requests. The block grants one at a time and drives the shared bus signals: turn index, internal push, internal pop, data.
- It holds off while the destination interface's output FIFO is full, and gives up on a stalled grant after a bounded wait so one blocked destination cannot starve the others.
- Sits between the four per-side bus interfaces and their output FIFOs inside each router instance of the mesh.

Parameters:
- PCKG_SZ, 40, packet width in bits.
- WAIT_MAX, 16, max cycles a grant may wait on a full destination before it is skipped (>=1).
- CNT_W, 8, width of the skip counter.

Ports:
- clk  input  1  clock.
- rst  input  1  reset.
- pndng_i  input  4  per-interface request; bit k = interface k has a head packet.
- data_out_i  input  4*PCKG_SZ  head packets; slice k = bits [k*PCKG_SZ +: PCKG_SZ].
- tgt_i  input  8  decoded destination interface per requester; slice k = bits [2k+1:2k].
- full_i  input  4  output-FIFO full flag per destination interface.
- trn  output  2  index of the currently granted interface.
- push_i  output  1  one-cycle push of data_in_i into destination tgt.
- pop_i  output  1  one-cycle pop of the granted interface's input FIFO.
- data_in_i  output  PCKG_SZ  latched packet of the granted interface.
- busy  output  1  high whenever the state is not IDLE.
- skip_cnt  output  CNT_W  saturating count of skipped grants.

Behaviour:
- Interface decision: single clock clk; reset rst is asynchronous, active-high.
- Reset values: state=IDLE, ptr=3 (so interface 0 is served first), trn=0, push_i=0, pop_i=0, data_in_i=0, busy=0, skip_cnt=0, wait counter=0.
- Reset mid-operation: all outputs take reset values immediately. No partial push or pop completes.
- push_i, pop_i and busy are decoded from the registered state (Moore); they have no combinational path from inputs.
- IDLE:
  - If pndng_i==0, stay in IDLE.
  - Else select sel = first k with pndng_i[k]=1, searching in order ptr+1, ptr+2, ptr+3, ptr (mod 4).
  - Register trn<=sel, data_in_i<=slice sel, tgt_l<=tgt_i slice sel, wait<=0. Go to CHECK.
- CHECK:
  - If pndng_i[trn]==0 (request withdrawn): ptr<=trn, go to IDLE. No push, no pop.
  - Else if full_i[tgt_l]==0: go to PUSH.
  - Else if wait==WAIT_MAX-1: go to IDLE, ptr<=trn, skip_cnt+=1 (saturates at all-ones).
  - Else wait<=wait+1 and stay in CHECK.
- PUSH: push_i=1 for exactly this cycle. Go to POP.
- POP: pop_i=1 for exactly this cycle. ptr<=trn. Go to IDLE.
- Timing:
  - trn and data_in_i stay stable from the cycle after the grant decision through POP.
  - Uncontended latency: request seen in IDLE at cycle 0 -> CHECK at cycle 1 -> push_i at cycle 2 -> pop_i at cycle 3 -> IDLE at cycle 4. That is 4 cycles per packet.
- push_i and pop_i are never high in the same cycle. At most one push per grant.
- pndng_i and full_i changes during PUSH or POP are ignored.
- tgt_l is sampled once at grant time. Later changes to tgt_i do not affect the grant in progress.
- A requester whose tgt equals its own index is legal and gets no special handling.
- Skipped grants and withdrawn requests advance ptr, so the skipped interface becomes lowest priority.

Test Plan:
1. Reset, then pndng_i=4'b0100, tgt_i slice2=1, full_i=0 -> cycle 1: trn=2, data_in_i=slice2. Cycle 2: push_i=1. Cycle 3: pop_i=1. Cycle 4: busy=0.
2. pndng_i=4'b1111 held, full_i=0 -> grant order 0,1,2,3,0 with push_i pulses exactly 4 cycles apart.
3. WAIT_MAX=4, interface 1 targets 3, full_i[3]=1 held, pndng_i=4'b0010 -> CHECK lasts 4 cycles, then IDLE with skip_cnt=1 and no push_i/pop_i. Next grant is interface 1 again (only requester). skip_cnt=2 after the second timeout.
4. As test 3, but full_i[3] drops after 2 CHECK cycles -> push_i one cycle after the drop, then pop_i, and skip_cnt stays 0.
5. Assert rst asynchronously while push_i=1 -> push_i, pop_i, trn and busy go to 0 immediately. After release, interface 0 has priority.
6. Grant interface 0 with full destination, then drop pndng_i[0] in CHECK -> IDLE next cycle, no push/pop, next grant goes to interface 1 if it is pending.
